// File: rtl/adder_seq_pkg.sv
// Shared definitions for the sliced add/subtract sequencer: FSM encoding and default geometry.
package adder_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_SLICE_W  = 8;
    localparam int unsigned DEFAULT_N_SLICES = 2;

endpackage

// File: rtl/adder_slice.sv
// Purely combinational SLICE_W-bit ripple-carry adder built from full_adder cells.
module adder_slice
    import adder_seq_pkg::*;
#(
    parameter int unsigned SLICE_W = DEFAULT_SLICE_W
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               c_in,
    output logic [SLICE_W-1:0] s,
    output logic               c_out
);

    logic [SLICE_W:0] c;

    assign c[0]  = c_in;
    assign c_out = c[SLICE_W];

    for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .c_in (c[i]),
            .o    (s[i]),
            .c_out(c[i+1])
        );
    end

endmodule

// File: rtl/full_adder.sv
// 1-bit full-adder cell used as the building block of the ripple slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic o,
    output logic c_out
);

    assign o     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/adder_slice_seq.sv
// W-bit add/subtract computed one slice per cycle through a single shared adder slice,
// with valid/ready handshakes on operand and result sides.
module adder_slice_seq
    import adder_seq_pkg::*;
#(
    parameter int unsigned SLICE_W  = DEFAULT_SLICE_W,
    parameter int unsigned N_SLICES = DEFAULT_N_SLICES,
    localparam int unsigned W       = SLICE_W * N_SLICES
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op_sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   result,
    output logic         ovf
);

    localparam int unsigned IdxW = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_SLICES - 1);

    state_t              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic                carry_q, carry_d;
    logic [W-1:0]        a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic                ovf_q, ovf_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;

    logic [SLICE_W-1:0]  a_slice, b_slice, s_slice;
    logic                c_slice;

    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int unsigned i = 0; i < N_SLICES; i++) begin
            if (idx_q == IdxW'(i)) begin
                a_slice = a_q[i*SLICE_W +: SLICE_W];
                b_slice = b_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    adder_slice #(
        .SLICE_W(SLICE_W)
    ) u_slice (
        .a    (a_slice),
        .b    (b_slice),
        .c_in (carry_q),
        .s    (s_slice),
        .c_out(c_slice)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                // in_ready_q gates the accept so nothing is taken in the cycle after reset release
                if (in_valid && in_ready_q) begin
                    a_d     = a;
                    b_d     = op_sub ? ~b : b;
                    carry_d = op_sub;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int unsigned i = 0; i < N_SLICES; i++) begin
                    if (idx_q == IdxW'(i)) begin
                        sum_d[i*SLICE_W +: SLICE_W] = s_slice;
                    end
                end
                carry_d = c_slice;
                if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (s_slice[SLICE_W-1] != a_q[W-1]);
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = {carry_q, sum_q};
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_slice_seq.sv
// Self-checking bench for adder_slice_seq: directed corner cases, random ops, backpressure,
// back-to-back throughput and reset in the middle of an operation.
module tb_adder_slice_seq;

    localparam int W = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          op_sub = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [W:0]    result;
    logic          ovf;

    int n_checks = 0;
    int n_fail   = 0;

    adder_slice_seq #(
        .SLICE_W (8),
        .N_SLICES(2)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op_sub   (op_sub),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .ovf      (ovf)
    );

    always #5 clock = ~clock;

    // Reference: unsigned add gives a 17-bit sum; subtract gives (x-y) mod 2^16 with
    // carry_out = "no borrow", i.e. x >= y.
    function automatic logic [W:0] model_res(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic sub);
        int unsigned ux = int'(x);
        int unsigned uy = int'(y);
        int unsigned s;
        logic [W:0] r;
        if (sub) begin
            s = (ux - uy) & 32'h0000_FFFF;
            r = {(ux >= uy), s[W-1:0]};
        end else begin
            s = ux + uy;
            r = s[W:0];
        end
        return r;
    endfunction

    // Signed overflow: the exact signed result does not fit in W bits.
    function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic sub);
        int sx = int'($signed(x));
        int sy = int'($signed(y));
        int e  = sub ? (sx - sy) : (sx + sy);
        return (e > 32767) || (e < -32768);
    endfunction

    // Drives one full transaction and returns what was observed; checks live in the callers.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub,
                          output logic [W:0] res, output logic o, output int lat);
        int w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clock);
            w++;
        end
        a = x; b = y; op_sub = sub; in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); op_sub = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clock);
            @(negedge clock);
            lat++;
        end
        res = result;
        o = ovf;
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        n_checks++;
        if ({in_ready, out_valid, ovf} !== 3'b000)
            $display("FAIL reset_flags: got %b expected 000", {in_ready, out_valid, ovf});
        n_checks++;
        if (result !== '0) $display("FAIL reset_result: got %h expected 00000", result);
        if ({in_ready, out_valid, ovf} !== 3'b000 || result !== '0) n_fail++;
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b expected 0", in_ready);
        end
        @(negedge clock);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [5] = '{16'h00FF, 16'hFFFF, 16'h0005, 16'h8000, 16'h7FFF};
        logic [W-1:0] vb [5] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0001};
        logic         vs [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [W:0]   vr [5] = '{17'h00100, 17'h10000, 17'h0FFFE, 17'h17FFF, 17'h08000};
        logic         vo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W:0] res;
        logic o;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vs[i], res, o, lat);
            n_checks++;
            if (res !== vr[i]) begin
                n_fail++;
                $display("FAIL directed_result[%0d]: got %h expected %h", i, res, vr[i]);
            end
            n_checks++;
            if (o !== vo[i]) begin
                n_fail++;
                $display("FAIL directed_ovf[%0d]: got %b expected %b", i, o, vo[i]);
            end
            n_checks++;
            if (lat !== 2) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d expected 2", i, lat);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] x, y;
        logic s, o;
        logic [W:0] res;
        int lat;
        for (int i = 0; i < 40; i++) begin
            x = (i % 7 == 0) ? 16'h8000 : 16'($urandom);
            y = (i % 5 == 0) ? 16'h7FFF : 16'($urandom);
            s = 1'($urandom);
            run_op(x, y, s, res, o, lat);
            n_checks++;
            if (res !== model_res(x, y, s) || o !== model_ovf(x, y, s)) begin
                n_fail++;
                $display("FAIL random[%0d] %h %s %h: got %h/%b expected %h/%b", i, x,
                         s ? "-" : "+", y, res, o, model_res(x, y, s), model_ovf(x, y, s));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W:0] exp_r = model_res(16'h1111, 16'h2222, 1'b0);
        logic [W:0] res;
        logic o;
        int w = 0;
        int lat;
        a = 16'h1111; b = 16'h2222; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        while (!out_valid && w < 20) begin
            @(negedge clock);
            w++;
        end
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                a = 16'hFFFF; b = 16'hFFFF; op_sub = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            n_checks++;
            if (result !== exp_r || ovf !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: got res=%h ovf=%b ov=%b ir=%b expected %h 0 1 0",
                         k, result, ovf, out_valid, in_ready, exp_r);
            end
            @(posedge clock);
            @(negedge clock);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_release: got ir=%b ov=%b expected 1 0", in_ready, out_valid);
        end
        run_op(16'h0F0F, 16'h0101, 1'b1, res, o, lat);
        n_checks++;
        if (res !== 17'h10E0E || lat !== 2) begin
            n_fail++;
            $display("FAIL backpressure_next_op: got %h lat %0d expected 10e0e lat 2", res, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] exp_r [$];
        logic       exp_o [$];
        logic [W:0] er;
        logic eo;
        int last_acc = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 32; cyc++) begin
            @(negedge clock);
            if (out_valid) begin
                n_checks++;
                if (exp_r.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_spurious: got result %h expected no output", result);
                end else begin
                    er = exp_r.pop_front();
                    eo = exp_o.pop_front();
                    if (result !== er || ovf !== eo) begin
                        n_fail++;
                        $display("FAIL b2b_result: got %h/%b expected %h/%b", result, ovf, er, eo);
                    end
                end
            end
            in_valid = (cyc < 24);
            a = 16'($urandom); b = 16'($urandom); op_sub = 1'($urandom);
            if (in_valid && in_ready) begin
                exp_r.push_back(model_res(a, b, op_sub));
                exp_o.push_back(model_ovf(a, b, op_sub));
                if (last_acc >= 0) begin
                    n_checks++;
                    if (cyc - last_acc != 4) begin
                        n_fail++;
                        $display("FAIL b2b_spacing: got %0d expected 4", cyc - last_acc);
                    end
                end
                last_acc = cyc;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (exp_r.size() != 0 || last_acc < 0) begin
            n_fail++;
            $display("FAIL b2b_drain: got %0d pending, last accept %0d expected 0 pending",
                     exp_r.size(), last_acc);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W:0] res;
        logic o;
        int lat;
        @(negedge clock);
        a = 16'hABCD; b = 16'h1234; op_sub = 1'b1; in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || result !== '0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset_outputs: got ov=%b ir=%b res=%h ovf=%b expected 0 0 0 0",
                     out_valid, in_ready, result, ovf);
        end
        n_checks++;
        if ({dut.a_q, dut.b_q, dut.sum_q, dut.idx_q, dut.carry_q} !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset_regs: got a=%h b=%h sum=%h idx=%h c=%b expected all 0",
                     dut.a_q, dut.b_q, dut.sum_q, dut.idx_q, dut.carry_q);
        end
        repeat (2) @(negedge clock);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_ready_in_reset: got %b expected 0", in_ready);
        end
        reset_n = 1'b1;
        @(negedge clock);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_ready_after_release: got %b expected 1", in_ready);
        end
        run_op(16'h1234, 16'h4321, 1'b0, res, o, lat);
        n_checks++;
        if (res !== 17'h05555 || o !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_next_op: got %h/%b expected 05555/0", res, o);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
